// File: rtl/pkt_egress_buffer.sv
// -----------------------------------------------------------------------------
// pkt_egress_buffer
//
// Store-and-forward packet buffer. Words arriving on the in_* stream are kept
// in a circular RAM and a packet is released only once its end-of-packet word
// is stored, so the downstream stage never sees a packet stall mid-body.
// If a single packet fills the whole buffer before its EOP arrives, the
// buffer switches to cut-through for that packet so it can still drain.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   in_data       upstream data word
//   in_ctrl       upstream control, nonzero = header or EOP word
//   in_wr         upstream write strobe, one word per asserted cycle
//   in_rdy        buffer can accept a word this cycle
//   out_data      registered output word
//   out_ctrl      registered output control
//   out_wr        registered output strobe
//   out_rdy       downstream ready
//   pkts_ready    number of complete packets held
//   words_used    occupancy in words
//   oversize_err  sticky: a packet filled the buffer before its EOP
//   overflow_err  sticky: in_wr seen while in_rdy was low
// -----------------------------------------------------------------------------
module pkt_egress_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH_BITS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [DEPTH_BITS:0]   pkts_ready,
    output logic [DEPTH_BITS:0]   words_used,
    output logic                  oversize_err,
    output logic                  overflow_err
);

    localparam int DEPTH     = 1 << DEPTH_BITS;
    localparam int MEM_WIDTH = 1 + CTRL_WIDTH + DATA_WIDTH;

    localparam logic [DEPTH_BITS:0]   FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0]   ZERO_COUNT = {(DEPTH_BITS + 1){1'b0}};
    localparam logic [DEPTH_BITS:0]   ONE_COUNT  = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS-1:0] PTR_ZERO   = {DEPTH_BITS{1'b0}};
    localparam logic [DEPTH_BITS-1:0] PTR_ONE    = {{(DEPTH_BITS - 1){1'b0}}, 1'b1};
    localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO  = {CTRL_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        FR_HDR  = 1'b0,
        FR_BODY = 1'b1
    } framer_t;

    // Storage: {eop_tag, ctrl, data}. Not reset; occupancy is tracked by pointers.
    logic [MEM_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   words_used_q, words_used_d;
    logic [DEPTH_BITS:0]   pkts_ready_q, pkts_ready_d;
    framer_t               framer_q, framer_d;
    logic                  cut_through_q, cut_through_d;
    logic                  ct_eop_in_q, ct_eop_in_d;
    logic                  oversize_q, oversize_d;
    logic                  overflow_q, overflow_d;
    logic                  out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;

    logic                  in_rdy_s;
    logic                  wr_en_s;
    logic                  ovf_s;
    logic                  ctrl_nz_s;
    logic                  eop_in_s;
    logic                  rel_s;
    logic                  pop_s;
    logic [MEM_WIDTH-1:0]  rd_word_s;
    logic                  rd_eop_s;
    logic                  ct_eop_wr_s;
    logic                  ct_eop_pop_s;
    logic                  oversize_s;
    logic                  pkts_inc_s;
    logic                  pkts_dec_s;

    assign in_rdy_s  = (words_used_q != FULL_COUNT);
    assign wr_en_s   = in_wr & in_rdy_s;
    assign ovf_s     = in_wr & ~in_rdy_s;
    assign ctrl_nz_s = (in_ctrl != CTRL_ZERO);
    // Only a nonzero-ctrl word following body words closes a packet.
    assign eop_in_s  = wr_en_s & (framer_q == FR_BODY) & ctrl_nz_s;

    assign rel_s     = (pkts_ready_q != ZERO_COUNT) | cut_through_q;
    assign pop_s     = out_rdy & (words_used_q != ZERO_COUNT) & rel_s;
    assign rd_word_s = mem_q[rd_ptr_q];
    assign rd_eop_s  = rd_word_s[MEM_WIDTH-1];

    // While cutting through, the buffer holds only the oversize packet ahead of
    // anything else, so the first EOP written is that packet's EOP and the
    // first EOP popped is the same word. Neither touches pkts_ready.
    assign ct_eop_wr_s  = eop_in_s & cut_through_q & ~ct_eop_in_q;
    assign ct_eop_pop_s = pop_s & rd_eop_s & cut_through_q;
    assign pkts_inc_s   = eop_in_s & ~ct_eop_wr_s;
    assign pkts_dec_s   = pop_s & rd_eop_s & ~cut_through_q;

    // Full with no complete packet: nothing could ever be released otherwise.
    assign oversize_s = (words_used_q == FULL_COUNT) & (pkts_ready_q == ZERO_COUNT);

    // Next-state logic for pointers, counters, framer, flags and output stage.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        words_used_d  = words_used_q;
        pkts_ready_d  = pkts_ready_q;
        framer_d      = framer_q;
        cut_through_d = cut_through_q;
        ct_eop_in_d   = ct_eop_in_q;
        oversize_d    = oversize_q | oversize_s;
        overflow_d    = overflow_q | ovf_s;
        out_wr_d      = pop_s;
        out_data_d    = out_data_q;
        out_ctrl_d    = out_ctrl_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            out_ctrl_d = rd_word_s[MEM_WIDTH-2:DATA_WIDTH];
            out_data_d = rd_word_s[DATA_WIDTH-1:0];
        end else begin
            rd_ptr_d   = rd_ptr_q;
            out_ctrl_d = out_ctrl_q;
            out_data_d = out_data_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   words_used_d = words_used_q + ONE_COUNT;
            2'b01:   words_used_d = words_used_q - ONE_COUNT;
            default: words_used_d = words_used_q;
        endcase

        case ({pkts_inc_s, pkts_dec_s})
            2'b10:   pkts_ready_d = pkts_ready_q + ONE_COUNT;
            2'b01:   pkts_ready_d = pkts_ready_q - ONE_COUNT;
            default: pkts_ready_d = pkts_ready_q;
        endcase

        if (wr_en_s) begin
            case (framer_q)
                FR_HDR:  framer_d = ctrl_nz_s ? FR_HDR : FR_BODY;
                FR_BODY: framer_d = ctrl_nz_s ? FR_HDR : FR_BODY;
                default: framer_d = FR_HDR;
            endcase
        end else begin
            framer_d = framer_q;
        end

        // Clearing on the EOP pop wins; a still-full buffer re-arms next cycle.
        if (ct_eop_pop_s) begin
            cut_through_d = 1'b0;
        end else if (oversize_s) begin
            cut_through_d = 1'b1;
        end else begin
            cut_through_d = cut_through_q;
        end

        if (ct_eop_pop_s) begin
            ct_eop_in_d = 1'b0;
        end else if (ct_eop_wr_s) begin
            ct_eop_in_d = 1'b1;
        end else begin
            ct_eop_in_d = ct_eop_in_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            words_used_q  <= ZERO_COUNT;
            pkts_ready_q  <= ZERO_COUNT;
            framer_q      <= FR_HDR;
            cut_through_q <= 1'b0;
            ct_eop_in_q   <= 1'b0;
            oversize_q    <= 1'b0;
            overflow_q    <= 1'b0;
            out_wr_q      <= 1'b0;
            out_data_q    <= DATA_ZERO;
            out_ctrl_q    <= CTRL_ZERO;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            words_used_q  <= words_used_d;
            pkts_ready_q  <= pkts_ready_d;
            framer_q      <= framer_d;
            cut_through_q <= cut_through_d;
            ct_eop_in_q   <= ct_eop_in_d;
            oversize_q    <= oversize_d;
            overflow_q    <= overflow_d;
            out_wr_q      <= out_wr_d;
            out_data_q    <= out_data_d;
            out_ctrl_q    <= out_ctrl_d;
        end
    end

    // Packet RAM write port; the EOP tag travels with the word.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {eop_in_s, in_ctrl, in_data};
        end
    end

    assign in_rdy       = in_rdy_s;
    assign out_data     = out_data_q;
    assign out_ctrl     = out_ctrl_q;
    assign out_wr       = out_wr_q;
    assign pkts_ready   = pkts_ready_q;
    assign words_used   = words_used_q;
    assign oversize_err = oversize_q;
    assign overflow_err = overflow_q;

endmodule
